// File: rtl/knn_mem_arbiter.sv
// Two-requester arbiter sharing one memory port between the CPU and the k-NN accelerator.
// Holds each grant until mem_ready; a watchdog ends stalled grants and pulses timeout_err.
module knn_mem_arbiter #(
  parameter bit          ACC_PRIORITY = 1'b0,
  parameter logic [31:0] TIMEOUT      = 32'd1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cpu_mem_valid,
  input  logic [31:0] cpu_mem_addr,
  input  logic [31:0] cpu_mem_wdata,
  input  logic [3:0]  cpu_mem_wstrb,
  output logic        cpu_mem_ready,
  output logic [31:0] cpu_mem_rdata,
  input  logic        acc_mem_valid,
  input  logic        acc_mem_write,
  input  logic [31:0] acc_mem_addr,
  input  logic [31:0] acc_mem_wdata,
  output logic        acc_mem_ready,
  output logic [31:0] acc_mem_rdata,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        timeout_err,
  output logic        last_grant
);

  typedef enum logic [1:0] {IDLE, GNT_CPU, GNT_ACC} state_t;

  localparam logic [15:0] TMO = TIMEOUT[15:0];

  state_t      r_state, w_next;
  logic [15:0] r_wcnt;
  logic        r_last_grant;
  logic        w_busy, w_timeout;

  assign w_busy    = (r_state != IDLE);
  // Completion by mem_ready takes precedence over the watchdog in the same cycle.
  assign w_timeout = w_busy && (r_wcnt == TMO) && !mem_ready;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (cpu_mem_valid && acc_mem_valid)
          w_next = (ACC_PRIORITY || !r_last_grant) ? GNT_ACC : GNT_CPU;
        else if (cpu_mem_valid)
          w_next = GNT_CPU;
        else if (acc_mem_valid)
          w_next = GNT_ACC;
      end
      GNT_CPU, GNT_ACC: begin
        if (mem_ready || w_timeout)
          w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_wcnt       <= 16'd0;
      r_last_grant <= 1'b1;
    end else begin
      r_state <= w_next;
      if (!w_busy && w_next != IDLE) begin
        r_wcnt       <= 16'd0;
        r_last_grant <= (w_next == GNT_ACC);
      end else if (w_busy && !mem_ready && r_wcnt != 16'hFFFF) begin
        r_wcnt <= r_wcnt + 16'd1;
      end
    end
  end

  always_comb begin
    mem_valid     = 1'b0;
    mem_addr      = 32'h0;
    mem_wdata     = 32'h0;
    mem_wstrb     = 4'h0;
    cpu_mem_ready = 1'b0;
    cpu_mem_rdata = 32'h0;
    acc_mem_ready = 1'b0;
    acc_mem_rdata = 32'h0;
    timeout_err   = w_timeout;
    last_grant    = r_last_grant;
    case (r_state)
      GNT_CPU: begin
        mem_valid     = !w_timeout;
        mem_addr      = cpu_mem_addr;
        mem_wdata     = cpu_mem_wdata;
        mem_wstrb     = cpu_mem_wstrb;
        cpu_mem_ready = mem_ready || w_timeout;
        cpu_mem_rdata = w_timeout ? 32'h0 : mem_rdata;
      end
      GNT_ACC: begin
        mem_valid     = !w_timeout;
        mem_addr      = acc_mem_addr;
        mem_wdata     = acc_mem_wdata;
        mem_wstrb     = acc_mem_write ? 4'hF : 4'h0;
        acc_mem_ready = mem_ready || w_timeout;
        acc_mem_rdata = w_timeout ? 32'h0 : mem_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_knn_mem_arbiter.sv
// Bench for knn_mem_arbiter: two instances (round-robin/TIMEOUT=4, ACC priority/TIMEOUT=7)
// share stimulus and are checked every cycle against a transaction-level owner/wait model.
module tb_knn_mem_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cpu_v, acc_v, acc_w, mem_ready;
  logic [31:0] cpu_addr, cpu_wd, acc_addr, acc_wd, mem_rdata;
  logic [3:0]  cpu_ws;

  logic        cpu_rdy [2];
  logic [31:0] cpu_rd  [2];
  logic        acc_rdy [2];
  logic [31:0] acc_rd  [2];
  logic        mv      [2];
  logic [31:0] maddr   [2];
  logic [31:0] mwd     [2];
  logic [3:0]  mws     [2];
  logic        terr    [2];
  logic        lg      [2];

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    knn_mem_arbiter #(
      .ACC_PRIORITY(k == 1),
      .TIMEOUT     (k == 0 ? 32'd4 : 32'd7)
    ) u_dut (
      .clk          (clk),
      .resetn       (resetn),
      .cpu_mem_valid(cpu_v),
      .cpu_mem_addr (cpu_addr),
      .cpu_mem_wdata(cpu_wd),
      .cpu_mem_wstrb(cpu_ws),
      .cpu_mem_ready(cpu_rdy[k]),
      .cpu_mem_rdata(cpu_rd[k]),
      .acc_mem_valid(acc_v),
      .acc_mem_write(acc_w),
      .acc_mem_addr (acc_addr),
      .acc_mem_wdata(acc_wd),
      .acc_mem_ready(acc_rdy[k]),
      .acc_mem_rdata(acc_rd[k]),
      .mem_valid    (mv[k]),
      .mem_addr     (maddr[k]),
      .mem_wdata    (mwd[k]),
      .mem_wstrb    (mws[k]),
      .mem_ready    (mem_ready),
      .mem_rdata    (mem_rdata),
      .timeout_err  (terr[k]),
      .last_grant   (lg[k])
    );
  end

  int total = 0;
  int bad   = 0;

  // Model: owner 0 = nobody, 1 = CPU, 2 = ACC; wt = cycles spent waiting in the grant.
  int TO  [2] = '{4, 7};
  int PRI [2] = '{0, 1};
  int own [2];
  int wt  [2];
  bit last[2];

  // Observations for directed-step summaries.
  int cnt_cpu[2], cnt_acc[2], cnt_err[2], cnt_mv[2];
  logic [31:0] cap_crd, cap_mwd;
  logic [3:0]  cap_ws;
  logic        mv_seen;

  task automatic clr_counts();
    for (int k = 0; k < 2; k++) begin
      cnt_cpu[k] = 0; cnt_acc[k] = 0; cnt_err[k] = 0; cnt_mv[k] = 0;
    end
  endtask

  task automatic check();
    for (int k = 0; k < 2; k++) begin
      bit          to;
      logic [98:0] e_bus, o_bus;
      logic [33:0] e_c, o_c, e_a, o_a;
      logic [1:0]  e_m, o_m;
      logic [31:0] ea, ewd;
      logic [3:0]  ews;
      to  = own[k] != 0 && wt[k] == TO[k] && !mem_ready;
      ea  = own[k] == 1 ? cpu_addr : own[k] == 2 ? acc_addr : 32'h0;
      ewd = own[k] == 1 ? cpu_wd   : own[k] == 2 ? acc_wd   : 32'h0;
      ews = own[k] == 1 ? cpu_ws   : own[k] == 2 ? (acc_w ? 4'hF : 4'h0) : 4'h0;
      e_bus = {3'b0, own[k] != 0 && !to, ea, ewd, ews, 26'h0};
      o_bus = {3'b0, mv[k], maddr[k], mwd[k], mws[k], 26'h0};
      e_c = {1'b0, own[k] == 1 && (mem_ready || to), (own[k] == 1 && !to) ? mem_rdata : 32'h0};
      o_c = {1'b0, cpu_rdy[k], cpu_rd[k]};
      e_a = {1'b0, own[k] == 2 && (mem_ready || to), (own[k] == 2 && !to) ? mem_rdata : 32'h0};
      o_a = {1'b0, acc_rdy[k], acc_rd[k]};
      e_m = {to, last[k]};
      o_m = {terr[k], lg[k]};
      total++;
      assert (o_bus === e_bus) else begin bad++; $error("FAIL mem_bus[%0d] got=%h exp=%h", k, o_bus, e_bus); end
      total++;
      assert (o_c === e_c) else begin bad++; $error("FAIL cpu_rsp[%0d] got=%h exp=%h", k, o_c, e_c); end
      total++;
      assert (o_a === e_a) else begin bad++; $error("FAIL acc_rsp[%0d] got=%h exp=%h", k, o_a, e_a); end
      total++;
      assert (o_m === e_m) else begin bad++; $error("FAIL err_last[%0d] got=%b exp=%b", k, o_m, e_m); end
      cnt_cpu[k] += int'(cpu_rdy[k]);
      cnt_acc[k] += int'(acc_rdy[k]);
      cnt_err[k] += int'(terr[k]);
      cnt_mv[k]  += int'(mv[k]);
    end
    mv_seen = mv[0];
    if (cpu_rdy[0]) cap_crd = cpu_rd[0];
    if (mv[0]) begin cap_mwd = mwd[0]; cap_ws = mws[0]; end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (!resetn) begin
        own[k] = 0; wt[k] = 0; last[k] = 1'b1;
      end else if (own[k] == 0) begin
        int g;
        g = 0;
        if (cpu_v && acc_v) g = (PRI[k] == 1 || last[k] == 1'b0) ? 2 : 1;
        else if (cpu_v)     g = 1;
        else if (acc_v)     g = 2;
        if (g != 0) begin own[k] = g; wt[k] = 0; last[k] = (g == 2); end
      end else if (mem_ready || wt[k] == TO[k]) begin
        own[k] = 0;
      end else if (wt[k] < 65535) begin
        wt[k]++;
      end
    end
  endtask

  // Inputs are set at the falling edge; check 1 time unit later, then advance the model.
  task automatic step();
    #1 check();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0; cpu_v = 1'b1; acc_v = 1'b0; acc_w = 1'b0; mem_ready = 1'b0;
    cpu_addr = 32'h0000_1000; cpu_wd = 32'h0; cpu_ws = 4'h0;
    acc_addr = 32'h0; acc_wd = 32'h0; mem_rdata = 32'h0;
    cap_crd = 32'h0; cap_mwd = 32'h0; cap_ws = 4'h0; mv_seen = 1'b0;
    clr_counts();
    @(posedge clk);
    model_edge();
    @(negedge clk);

    // Reset held with a CPU request pending, then first grant one cycle after release.
    step(); step();
    resetn = 1'b1;
    step(); step();
    total++;
    assert (maddr[0] === 32'h0000_1000) else begin bad++; $error("FAIL first_addr got=%h exp=%h", maddr[0], 32'h0000_1000); end

    // CPU read with two wait states returning 0xAB.
    cpu_v = 1'b0; do_reset();
    cpu_v = 1'b1; cpu_addr = 32'h0001_0004; cpu_ws = 4'h0; mem_rdata = 32'h0000_00AB;
    clr_counts();
    step(); step(); step();
    mem_ready = 1'b1; step();
    mem_ready = 1'b0; cpu_v = 1'b0; step();
    total++;
    assert (cnt_cpu[0] === 1 && cnt_acc[0] === 0 && cap_crd === 32'h0000_00AB)
      else begin bad++; $error("FAIL cpu_read got=%0d/%0d/%h exp=1/0/000000ab", cnt_cpu[0], cnt_acc[0], cap_crd); end

    // Both requesting continuously, memory answers the cycle after each request.
    do_reset();
    cpu_v = 1'b1; acc_v = 1'b1; clr_counts(); mv_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      mem_ready = mv_seen && !mem_ready;
      step();
    end
    total++;
    assert (cnt_cpu[0] === 2 && cnt_acc[0] === 2)
      else begin bad++; $error("FAIL rr_alt got=%0d/%0d exp=2/2", cnt_cpu[0], cnt_acc[0]); end
    total++;
    assert (cnt_cpu[1] === 0 && cnt_acc[1] === 4)
      else begin bad++; $error("FAIL acc_pri got=%0d/%0d exp=0/4", cnt_cpu[1], cnt_acc[1]); end

    // ACC write then ACC read strobes.
    cpu_v = 1'b0; acc_v = 1'b0; mem_ready = 1'b0; do_reset();
    acc_v = 1'b1; acc_w = 1'b1; acc_addr = 32'h0002_0010; acc_wd = 32'h0000_1234;
    step(); step();
    total++;
    assert (cap_ws === 4'hF && cap_mwd === 32'h0000_1234)
      else begin bad++; $error("FAIL acc_wr got=%h/%h exp=f/00001234", cap_ws, cap_mwd); end
    mem_ready = 1'b1; step();
    mem_ready = 1'b0; acc_w = 1'b0; step(); step();
    total++;
    assert (cap_ws === 4'h0) else begin bad++; $error("FAIL acc_rd got=%h exp=0", cap_ws); end
    mem_ready = 1'b1; step();
    mem_ready = 1'b0; acc_v = 1'b0; step();

    // Watchdog: memory never ready (TIMEOUT=4 on instance 0).
    do_reset();
    cpu_v = 1'b1; clr_counts();
    for (int i = 0; i < 7; i++) step();
    total++;
    assert (cnt_mv[0] === 4 && cnt_err[0] === 1 && cnt_cpu[0] === 1)
      else begin bad++; $error("FAIL timeout got=%0d/%0d/%0d exp=4/1/1", cnt_mv[0], cnt_err[0], cnt_cpu[0]); end

    // Watchdog race: mem_ready arrives in the terminating cycle.
    cpu_v = 1'b0; do_reset();
    cpu_v = 1'b1; clr_counts(); mem_rdata = 32'h5A5A_0001;
    for (int i = 0; i < 5; i++) step();
    mem_ready = 1'b1; step();
    mem_ready = 1'b0; cpu_v = 1'b0; step();
    total++;
    assert (cnt_err[0] === 0 && cnt_cpu[0] === 1 && cap_crd === 32'h5A5A_0001)
      else begin bad++; $error("FAIL tmo_race got=%0d/%0d/%h exp=0/1/5a5a0001", cnt_err[0], cnt_cpu[0], cap_crd); end

    // Randomized traffic, including dropped valids, stray mem_ready and mid-grant resets.
    for (int i = 0; i < 600; i++) begin
      resetn    = ($urandom_range(0, 99) != 0);
      cpu_v     = (cpu_v && $urandom_range(0, 15) != 0) || ($urandom_range(0, 2) == 0);
      acc_v     = (acc_v && $urandom_range(0, 15) != 0) || ($urandom_range(0, 2) == 0);
      acc_w     = $urandom_range(0, 1) == 1;
      cpu_addr  = $urandom; cpu_wd = $urandom; cpu_ws = 4'($urandom);
      acc_addr  = $urandom; acc_wd = $urandom;
      mem_ready = ($urandom_range(0, 3) == 0);
      mem_rdata = $urandom;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
